// File: rtl/alu_fu_if.sv
// alu_fu_if: issue, PRF read, mispredict and CDB signals of the ALU functional unit.
package alu_fu_pkg;
  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [6:0]  pd;
    logic [6:0]  ps1;
    logic [6:0]  ps2;
    logic [31:0] imm;
    logic [4:0]  rob_index;
  } rs_data_t;
  typedef struct packed {
    logic [6:0]  pd;
    logic [31:0] data;
    logic [4:0]  rob;
  } q_ent_t;
endpackage

interface alu_fu_if;
  import alu_fu_pkg::*;
  logic        issue_valid;
  rs_data_t    issue_data;
  logic [6:0]  prf_raddr1;
  logic [6:0]  prf_raddr2;
  logic [31:0] prf_rdata1;
  logic [31:0] prf_rdata2;
  logic        mispredict;
  logic [4:0]  mispredict_tag;
  logic [4:0]  rob_head;
  logic        fu_ready;
  logic        cdb_valid;
  logic [6:0]  cdb_pd;
  logic [31:0] cdb_data;
  logic [4:0]  cdb_rob_index;
  logic        cdb_grant;
  modport master (
    output issue_valid, issue_data, prf_rdata1, prf_rdata2, mispredict, mispredict_tag, rob_head, cdb_grant,
    input  prf_raddr1, prf_raddr2, fu_ready, cdb_valid, cdb_pd, cdb_data, cdb_rob_index
  );
  modport slave (
    input  issue_valid, issue_data, prf_rdata1, prf_rdata2, mispredict, mispredict_tag, rob_head, cdb_grant,
    output prf_raddr1, prf_raddr2, fu_ready, cdb_valid, cdb_pd, cdb_data, cdb_rob_index
  );
endinterface

// File: rtl/alu_fu.sv
// alu_fu: single-cycle RV32I ALU with a 2-entry result queue feeding the CDB.
// Define ALU_MUL_EN to add MUL (R-type, func7=0000001, func3=000).
module alu_fu
  import alu_fu_pkg::*;
#(
  parameter int ROB_DEPTH = 16,
  parameter int QDEPTH    = 2
) (
  input logic   clk,
  input logic   reset,
  alu_fu_if.slave bus
);
  rs_data_t    w_d;
  logic        w_r, w_i, w_lui;
  logic [31:0] w_a, w_b, w_sra, w_alu, w_base, w_res;
  q_ent_t      r_q [QDEPTH];
  logic [1:0]  r_cnt;
  q_ent_t      w_new, w_n0, w_n1;
  logic        w_pop, w_k0, w_k1, w_push;
  logic [1:0]  w_cnt_n;
  function automatic logic [4:0] age(input logic [4:0] x, input logic [4:0] h);
    logic [5:0] d;
    d = {1'b0, x} - {1'b0, h};
    return d[5] ? d[4:0] + 5'(ROB_DEPTH) : d[4:0];
  endfunction
  function automatic logic young(input logic [4:0] x);
    return bus.mispredict && (age(x, bus.rob_head) > age(bus.mispredict_tag, bus.rob_head));
  endfunction
  assign w_d            = bus.issue_data;
  assign bus.prf_raddr1 = w_d.ps1;
  assign bus.prf_raddr2 = w_d.ps2;
  assign w_r            = w_d.opcode == 7'b0110011;
  assign w_i            = w_d.opcode == 7'b0010011;
  assign w_lui          = w_d.opcode == 7'b0110111;
  assign w_a            = bus.prf_rdata1;
  assign w_b            = w_r ? bus.prf_rdata2 : w_d.imm;
  assign w_sra          = $signed(w_a) >>> w_b[4:0];
  always_comb begin
    w_alu = '0;
    case (w_d.func3)
      3'd0: w_alu = (w_r && w_d.func7[5]) ? w_a - w_b : w_a + w_b;
      3'd1: w_alu = w_a << w_b[4:0];
      3'd2: w_alu = {31'd0, $signed(w_a) < $signed(w_b)};
      3'd3: w_alu = {31'd0, w_a < w_b};
      3'd4: w_alu = w_a ^ w_b;
      3'd5: w_alu = w_d.func7[5] ? w_sra : w_a >> w_b[4:0];
      3'd6: w_alu = w_a | w_b;
      3'd7: w_alu = w_a & w_b;
    endcase
  end
  assign w_base = w_lui ? w_d.imm : (w_r || w_i) ? w_alu : '0;
`ifdef ALU_MUL_EN
  assign w_res = (w_r && w_d.func7 == 7'b0000001) ? ((w_d.func3 == 3'd0) ? w_a * w_b : '0) : w_base;
`else
  assign w_res = w_base;
`endif
  // Head sits in slot 0; survivors of pop/kill shift down, then the new result fills behind them.
  always_comb begin
    w_new   = '{pd: w_d.pd, data: w_res, rob: w_d.rob_index};
    w_pop   = bus.cdb_valid && bus.cdb_grant;
    w_k0    = r_cnt != 2'd0 && !w_pop && !young(r_q[0].rob);
    w_k1    = r_cnt == 2'd2 && !young(r_q[1].rob);
    w_push  = bus.issue_valid && r_cnt != 2'd2 && !young(w_d.rob_index);
    w_n0    = w_k0 ? r_q[0] : w_k1 ? r_q[1] : w_new;
    w_n1    = (w_k0 && w_k1) ? r_q[1] : w_new;
    w_cnt_n = {1'b0, w_k0} + {1'b0, w_k1} + {1'b0, w_push};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q[0] <= '0;
      r_q[1] <= '0;
      r_cnt  <= '0;
    end else begin
      r_q[0] <= w_n0;
      r_q[1] <= w_n1;
      r_cnt  <= w_cnt_n;
    end
  end
  assign bus.cdb_valid     = r_cnt != 2'd0;
  assign bus.cdb_pd        = r_q[0].pd;
  assign bus.cdb_data      = r_q[0].data;
  assign bus.cdb_rob_index = r_q[0].rob;
  // Readiness looks one issue ahead and never credits a pending grant.
  assign bus.fu_ready = ({1'b0, r_cnt} + {2'b0, bus.issue_valid}) <= 3'd1;
  ovf_a: assert property (@(posedge clk) disable iff (!reset) !(bus.issue_valid && r_cnt == 2'd2))
    else $error("alu_fu: issue while result queue full");
endmodule

// File: tb/tb_alu_fu.sv
// tb_alu_fu: table-driven ALU vectors plus directed queue, backpressure and mispredict sequences.
module tb_alu_fu;
  import alu_fu_pkg::*;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LUI = 7'b0110111, OP_LD = 7'b0000011;
  logic clk = 1'b0;
  logic reset;
  int   pass_cnt = 0;
  int   tot_cnt  = 0;
  alu_fu_if bus();
  alu_fu u_dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;
  vec_t v [17];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask
  task automatic set_issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                           input logic [6:0] pd, input logic [4:0] rob);
    rs_data_t d;
    d.opcode = op; d.func3 = f3; d.func7 = f7; d.pd = pd;
    d.ps1 = 7'd3; d.ps2 = 7'd4; d.imm = imm; d.rob_index = rob;
    bus.issue_data  = d;
    bus.prf_rdata1  = a;
    bus.prf_rdata2  = b;
    bus.issue_valid = 1'b1;
  endtask
  task automatic addi(input logic [31:0] val, input logic [4:0] rob);
    set_issue(OP_I, 3'd0, 7'd0, val, 32'hDEADBEEF, 32'd0, 7'd1, rob);
  endtask
  task automatic idle();
    bus.issue_valid = 1'b0;
  endtask
  initial begin
    v[0]  = '{"add_f7_01", OP_R, 3'd0, 7'h01, 32'd7, 32'hFFFFFFFE, 32'd0,
`ifdef ALU_MUL_EN
              32'hFFFFFFF2};
`else
              32'd5};
`endif
    v[1]  = '{"mul_wrap", OP_R, 3'd0, 7'h01, 32'h10000, 32'h10000, 32'd0,
`ifdef ALU_MUL_EN
              32'd0};
`else
              32'h20000};
`endif
    v[2]  = '{"sub", OP_R, 3'd0, 7'h20, 32'd3, 32'd5, 32'd0, 32'hFFFFFFFE};
    v[3]  = '{"sll_shamt5", OP_R, 3'd1, 7'h00, 32'd1, 32'h23, 32'd0, 32'd8};
    v[4]  = '{"slt", OP_R, 3'd2, 7'h00, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0};
    v[5]  = '{"sltu", OP_R, 3'd3, 7'h00, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd1};
    v[6]  = '{"xor", OP_R, 3'd4, 7'h00, 32'hF0F0, 32'hFF00, 32'd0, 32'h0FF0};
    v[7]  = '{"srl", OP_R, 3'd5, 7'h00, 32'h80000000, 32'd4, 32'd0, 32'h08000000};
    v[8]  = '{"sra", OP_R, 3'd5, 7'h20, 32'h80000000, 32'd4, 32'd0, 32'hF8000000};
    v[9]  = '{"srai", OP_I, 3'd5, 7'h20, 32'h80000000, 32'hDEADBEEF, 32'h404, 32'hF8000000};
    v[10] = '{"ori", OP_I, 3'd6, 7'h00, 32'h0F, 32'hDEADBEEF, 32'hF0, 32'hFF};
    v[11] = '{"andi", OP_I, 3'd7, 7'h00, 32'hFF, 32'hDEADBEEF, 32'hFFFFFFF0, 32'hF0};
    v[12] = '{"addi_f7_ign", OP_I, 3'd0, 7'h20, 32'd10, 32'hDEADBEEF, 32'h400, 32'h40A};
    v[13] = '{"slti", OP_I, 3'd2, 7'h00, 32'hFFFFFFFF, 32'hDEADBEEF, 32'd1, 32'd1};
    v[14] = '{"lui", OP_LUI, 3'd0, 7'h00, 32'h55, 32'hDEADBEEF, 32'h12345000, 32'h12345000};
    v[15] = '{"other_op", OP_LD, 3'd0, 7'h00, 32'd5, 32'hDEADBEEF, 32'd8, 32'd0};
    v[16] = '{"f7_01_f3_1", OP_R, 3'd1, 7'h01, 32'd3, 32'd2, 32'd0,
`ifdef ALU_MUL_EN
              32'd0};
`else
              32'd12};
`endif
    reset = 1'b0;
    bus.issue_valid = 1'b0; bus.issue_data = '0; bus.prf_rdata1 = '0; bus.prf_rdata2 = '0;
    bus.mispredict = 1'b0; bus.mispredict_tag = '0; bus.rob_head = '0; bus.cdb_grant = 1'b0;
    repeat (2) tick();
    chk("rst_valid", bus.cdb_valid, 0);
    chk("rst_data", bus.cdb_data, 0);
    chk("rst_pd", bus.cdb_pd, 0);
    chk("rst_rob", bus.cdb_rob_index, 0);
    chk("rst_ready", bus.fu_ready, 1);
    reset = 1'b1;
    tick();
    set_issue(OP_I, 3'd0, 7'd0, 32'd5, 32'hDEADBEEF, 32'hFFFFFFFD, 7'd9, 5'd2);
    chk("raddr1", bus.prf_raddr1, 3);
    chk("raddr2", bus.prf_raddr2, 4);
    tick(); idle();
    chk("addi_valid", bus.cdb_valid, 1);
    chk("addi_data", bus.cdb_data, 2);
    chk("addi_pd", bus.cdb_pd, 9);
    chk("addi_rob", bus.cdb_rob_index, 2);
    bus.cdb_grant = 1'b1; tick(); bus.cdb_grant = 1'b0;
    chk("addi_popped", bus.cdb_valid, 0);
    for (int i = 0; i < 17; i++) begin
      set_issue(v[i].op, v[i].f3, v[i].f7, v[i].a, v[i].b, v[i].imm, 7'(i + 1), 5'(i % 16));
      tick(); idle();
      chk({v[i].name, "_data"}, bus.cdb_data, v[i].exp);
      chk({v[i].name, "_pd"}, bus.cdb_pd, 32'(i + 1));
      chk({v[i].name, "_rob"}, bus.cdb_rob_index, 32'(i % 16));
      bus.cdb_grant = 1'b1; tick(); bus.cdb_grant = 1'b0;
    end
    addi(32'h10, 5'd3);
    chk("bp_ready0", bus.fu_ready, 1);
    tick(); addi(32'h20, 5'd4);
    chk("bp_ready1", bus.fu_ready, 0);
    tick(); idle();
    chk("bp_full_ready", bus.fu_ready, 0);
    chk("bp_head1", bus.cdb_data, 32'h10);
    tick();
    chk("bp_hold_valid", bus.cdb_valid, 1);
    chk("bp_hold_data", bus.cdb_data, 32'h10);
    bus.cdb_grant = 1'b1; tick();
    chk("bp_head2", bus.cdb_data, 32'h20);
    chk("bp_head2_rob", bus.cdb_rob_index, 4);
    chk("bp_ready2", bus.fu_ready, 1);
    tick(); bus.cdb_grant = 1'b0;
    chk("bp_empty", bus.cdb_valid, 0);
    addi(32'h11, 5'd5); tick(); idle();
    chk("pp_first", bus.cdb_data, 32'h11);
    bus.cdb_grant = 1'b1; addi(32'h33, 5'd6); tick(); idle();
    chk("pp_valid", bus.cdb_valid, 1);
    chk("pp_new_head", bus.cdb_data, 32'h33);
    tick(); bus.cdb_grant = 1'b0;
    chk("pp_count1", bus.cdb_valid, 0);
    bus.rob_head = 5'd14;
    addi(32'hAA, 5'd15); tick(); addi(32'hBB, 5'd1); tick(); idle();
    bus.mispredict = 1'b1; bus.mispredict_tag = 5'd0; tick(); bus.mispredict = 1'b0;
    chk("mp_valid", bus.cdb_valid, 1);
    chk("mp_keep_data", bus.cdb_data, 32'hAA);
    chk("mp_keep_rob", bus.cdb_rob_index, 15);
    chk("mp_ready", bus.fu_ready, 1);
    bus.cdb_grant = 1'b1; tick(); bus.cdb_grant = 1'b0;
    chk("mp_count1", bus.cdb_valid, 0);
    bus.mispredict = 1'b1; addi(32'hCC, 5'd2); tick(); idle(); bus.mispredict = 1'b0;
    chk("mp_kill_issue", bus.cdb_valid, 0);
    bus.mispredict = 1'b1; addi(32'hDD, 5'd0); tick(); idle(); bus.mispredict = 1'b0;
    chk("mp_keep_branch", bus.cdb_data, 32'hDD);
    bus.cdb_grant = 1'b1; tick(); bus.cdb_grant = 1'b0;
    bus.rob_head = 5'd0;
    addi(32'h31, 5'd1); tick(); addi(32'h51, 5'd5); tick(); idle();
    bus.mispredict = 1'b1; bus.mispredict_tag = 5'd2; bus.cdb_grant = 1'b1;
    tick(); bus.mispredict = 1'b0; bus.cdb_grant = 1'b0;
    chk("gk_empty", bus.cdb_valid, 0);
    addi(32'h77, 5'd7); tick(); idle();
    chk("mr_valid", bus.cdb_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("mr_valid_clr", bus.cdb_valid, 0);
    chk("mr_data_clr", bus.cdb_data, 0);
    chk("mr_ready", bus.fu_ready, 1);
    #2 reset = 1'b1;
    tick();
    chk("mr_stays_empty", bus.cdb_valid, 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end
endmodule

// File: doc/alu_fu.md
Name: alu_fu

Overview:
- Integer ALU functional unit directly downstream of the ALU reservation station.
- Takes each issued entry (issue strobe plus rs_data packet) and reads both source operands from the physical register file.
- Computes the RV32I result in the issue cycle and parks it in a 2-entry result queue until the CDB arbiter grants a broadcast slot.
- Drives fu_ready back to the reservation station and kills wrong-path results on mispredict.

Parameters:
- ROB_DEPTH, 16, ROB entries; modulus for rob_index age arithmetic.
- QDEPTH, 2, result queue entries; fixed at 2 because fu_ready timing depends on it.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- issue_valid  in  1  RS fu_issued; issue_data is valid this cycle
- issue_data  in  rs_data  Opcode, func3, func7, pd[6:0], ps1, ps2, imm[31:0], rob_index[4:0]
- prf_raddr1  out  7  = issue_data.ps1, combinational
- prf_raddr2  out  7  = issue_data.ps2, combinational
- prf_rdata1  in  32  combinational PRF read data for port 1
- prf_rdata2  in  32  combinational PRF read data for port 2
- mispredict  in  1  branch mispredict pulse
- mispredict_tag  in  5  ROB index of the mispredicted branch
- rob_head  in  5  ROB index of the oldest in-flight instruction
- fu_ready  out  1  unit can take an issue one cycle after this is sampled
- cdb_valid  out  1  queue head holds a result
- cdb_pd  out  7  destination physical register of the head result
- cdb_data  out  32  head result value
- cdb_rob_index  out  5  ROB index of the head result
- cdb_grant  in  1  arbiter accepts the head this cycle; pops the head at the clock edge

Behaviour:
- Reset (reset=0, asynchronous): queue empty, count=0, rd/wr pointers=0; cdb_valid=0; cdb_pd, cdb_data, cdb_rob_index=0; fu_ready=1.
- Operand A is always prf_rdata1.
- Operand B:
  - Opcode 0110011 (R-type): prf_rdata2.
  - Otherwise: imm (imm arrives sign-extended to 32 bits).
- R-type and I-type (0010011) ops by func3:
  - 000 ADD; SUB when R-type and func7[5]=1. I-type ignores func7 for ADDI.
  - 001 SLL.
  - 010 SLT, signed compare.
  - 011 SLTU, unsigned compare.
  - 100 XOR.
  - 101 SRL; SRA when func7[5]=1 (I-type func7 = imm[11:5]).
  - 110 OR.
  - 111 AND.
- Shift amount is B[4:0]. All arithmetic wraps modulo 2^32.
- LUI (0110111): result = imm (already shifted left by 12).
- Any other opcode: result 0, still queued and broadcast so the ROB entry completes.
- Latency: issue accepted in cycle t → result written to the queue at edge t → cdb_valid=1 in cycle t+1 if the queue was empty. Results broadcast in issue order (FIFO).
- Queue:
  - Push on issue_valid that is not killed.
  - Pop on cdb_valid && cdb_grant.
  - Push and pop in the same cycle: count unchanged; both pointers advance modulo QDEPTH.
  - cdb_* always reflect the head entry; they hold stable while cdb_valid=1 and cdb_grant=0.
- fu_ready = (count + issue_valid) <= 1, combinational. It deliberately ignores cdb_grant. This guarantees a free slot for an issue arriving one cycle after the RS samples fu_ready.
- Overflow: issue_valid while count=2 is a protocol error. Flag it with an assertion and drop the issue; count never exceeds 2.
- Age: age(x) = (x - rob_head) mod ROB_DEPTH, computed in 5 bits with explicit wrap at ROB_DEPTH.
- Mispredict, during a cycle with mispredict=1:
  - Every queued entry with age(rob_index) > age(mispredict_tag) is invalidated at the edge.
  - An incoming issue with age > age(mispredict_tag) is not pushed.
  - The branch's own entry and older entries are kept.
  - Survivors are compacted in order; count updates to the survivor total, combined with any same-cycle pop.
- Grant and kill together: if the head is granted in the same cycle it is killed, the pop still takes effect. The arbiter already consumed it; the ROB ignores it as wrong-path.
- Reset asserted mid-operation: queue cleared immediately, no CDB output until a new push.

Optional Feature:
- ALU_MUL_EN defined: R-type with func7=0000001 and func3=000 returns MUL (low 32 bits of A*B), same single-cycle latency. Other M-extension func3 values return 0.
- ALU_MUL_EN undefined: func7=0000001 decodes as a normal R-type op on func7[5]=0, i.e. func3=000 gives ADD.

Test Plan:
- Reset then ADDI: issue ps1 value 5, imm=-3, pd=9, rob_index=2 → cdb_valid next cycle, cdb_data=2, cdb_pd=9, cdb_rob_index=2.
- Backpressure: cdb_grant=0 with 2 back-to-back issues → count=2, fu_ready=0. Results 0x10 then 0x20 stay stable. Grant 2 cycles → broadcast in order, fu_ready returns to 1.
- Simultaneous push/pop with count=1 and grant=1 → count stays 1, new result becomes head the next cycle.
- Shift/compare: SRA A=0x80000000 by 4 → 0xF8000000. SLTU A=1, B=0xFFFFFFFF → 1. SLT with the same operands → 0.
- Mispredict wrap: rob_head=14, queue holds rob 15 and rob 1, mispredict_tag=0 → rob 15 retained, rob 1 killed, count=1.
- ALU_MUL_EN on: MUL 0x10000 × 0x10000 → 0. MUL 7 × -2 → 0xFFFFFFF2. With the macro off, the same 7/-2 encoding → 5 (ADD).
